// File: rtl/ro_sense_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
package ro_sense_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StGate,
    StSync,
    StCapture,
    StClear,
    StReport
  } state_e;

  localparam logic OSC_INV  = 1'b0;
  localparam logic OSC_NAND = 1'b1;

  localparam int unsigned DEF_GATE_CYCLES   = 10000;
  localparam int unsigned DEF_SETTLE_CYCLES = 64;
  localparam int unsigned DEF_SYNC_CYCLES   = 2;

  // Inverter ring has precedence when both rings are requested.
  function automatic logic lowest_osc(input logic [1:0] mask);
    return mask[OSC_INV] ? OSC_INV : OSC_NAND;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ro_measure_sequencer_if.sv
// Control, datapath and result signals of the measurement sequencer.
interface ro_measure_sequencer_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ACC_W = 24
);
  logic             start;
  logic             continuous;
  logic             abort;
  logic [1:0]       osc_mask;
  logic [CNT_W-1:0] cnt_in;
  logic             en_inv_osc;
  logic             en_nand_osc;
  logic             osc_sel;
  logic             cnt_clr;
  logic             cnt_en;
  logic [ACC_W-1:0] result_data;
  logic             result_osc;
  logic             result_sat;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  modport master (
    input  start, continuous, abort, osc_mask, cnt_in, result_ready,
    output en_inv_osc, en_nand_osc, osc_sel, cnt_clr, cnt_en,
    output result_data, result_osc, result_sat, result_valid, busy
  );

  modport slave (
    output start, continuous, abort, osc_mask, cnt_in, result_ready,
    input  en_inv_osc, en_nand_osc, osc_sel, cnt_clr, cnt_en,
    input  result_data, result_osc, result_sat, result_valid, busy
  );
endinterface

// File: rtl/ro_cycle_timer.sv
// Loadable down-counter; o_done is high on the last cycle of a loaded interval.
module ro_cycle_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_value;
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = r_run && (r_cnt == '0);

endmodule

// File: rtl/ro_measure_sequencer.sv
// Time-shares one gated ring counter between the inverter and NAND oscillators and
// reports one accumulated, tagged sum per oscillator over a valid/ready handshake.
module ro_measure_sequencer
  import ro_sense_pkg::*;
#(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned ACC_W         = 24,
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SYNC_CYCLES   = DEF_SYNC_CYCLES,
  parameter int unsigned AVG_LOG2      = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  ro_measure_sequencer_if.master bus
);

  localparam int unsigned N     = 1 << AVG_LOG2;
  localparam int unsigned IDX_W = AVG_LOG2 + 1;
  localparam int unsigned TMR_W = $clog2(max3(GATE_CYCLES, SETTLE_CYCLES, SYNC_CYCLES) + 1);

  localparam logic [IDX_W-1:0] N_IDX       = IDX_W'(N);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SYNC_LOAD   = TMR_W'(SYNC_CYCLES - 1);

  state_e           r_state, w_state_next;
  logic [1:0]       r_mask, w_mask_next;
  logic             r_osc, w_osc_next;
  logic [ACC_W-1:0] r_acc, w_acc_next;
  logic             r_sat, w_sat_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;

  logic             w_tmr_load;
  logic             w_tmr_clear;
  logic [TMR_W-1:0] w_tmr_value;
  logic             w_tmr_done;

  ro_cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_clear (w_tmr_clear),
    .i_value (w_tmr_value),
    .o_done  (w_tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_mask  <= '0;
      r_osc   <= OSC_INV;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      r_osc   <= w_osc_next;
      r_acc   <= w_acc_next;
      r_sat   <= w_sat_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    w_osc_next   = r_osc;
    w_acc_next   = r_acc;
    w_sat_next   = r_sat;
    w_idx_next   = r_idx;
    w_tmr_load   = 1'b0;
    w_tmr_clear  = 1'b0;
    w_tmr_value  = '0;

    case (r_state)
      StIdle: begin
        if (bus.start && (bus.osc_mask != 2'b00)) begin
          w_mask_next  = bus.osc_mask;
          w_osc_next   = lowest_osc(bus.osc_mask);
          w_state_next = StSettle;
        end
      end
      StSettle: begin
        if (w_tmr_done) begin
          w_state_next = StGate;
          w_tmr_load   = 1'b1;
          w_tmr_value  = GATE_LOAD;
        end
      end
      StGate: begin
        if (w_tmr_done) begin
          w_state_next = StSync;
          w_tmr_load   = 1'b1;
          w_tmr_value  = SYNC_LOAD;
        end
      end
      StSync: begin
        if (w_tmr_done) w_state_next = StCapture;
      end
      StCapture: begin
        w_acc_next   = r_acc + ACC_W'(bus.cnt_in);
        w_sat_next   = r_sat | (&bus.cnt_in);
        w_idx_next   = r_idx + 1'b1;
        w_state_next = (w_idx_next < N_IDX) ? StClear : StReport;
      end
      StClear: begin
        w_state_next = StGate;
        w_tmr_load   = 1'b1;
        w_tmr_value  = GATE_LOAD;
      end
      StReport: begin
        if (bus.result_ready) begin
          if ((r_osc == OSC_INV) && r_mask[OSC_NAND]) begin
            w_osc_next   = OSC_NAND;
            w_state_next = StSettle;
          end else if (bus.continuous && (bus.osc_mask != 2'b00)) begin
            w_mask_next  = bus.osc_mask;
            w_osc_next   = lowest_osc(bus.osc_mask);
            w_state_next = StSettle;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (bus.abort) w_state_next = StIdle;

    // Every fresh oscillator measurement starts from an empty accumulator.
    if ((w_state_next == StSettle) && (r_state != StSettle)) begin
      w_acc_next  = '0;
      w_sat_next  = 1'b0;
      w_idx_next  = '0;
      w_tmr_load  = 1'b1;
      w_tmr_value = SETTLE_LOAD;
    end

    if (w_state_next == StIdle) begin
      w_mask_next = '0;
      w_osc_next  = OSC_INV;
      w_acc_next  = '0;
      w_sat_next  = 1'b0;
      w_idx_next  = '0;
      w_tmr_load  = 1'b0;
      w_tmr_clear = 1'b1;
    end
  end

  logic w_busy;
  logic w_report;

  assign w_busy   = (r_state != StIdle);
  assign w_report = (r_state == StReport);

  assign bus.busy         = w_busy;
  assign bus.en_inv_osc   = w_busy && (r_osc == OSC_INV);
  assign bus.en_nand_osc  = w_busy && (r_osc == OSC_NAND);
  assign bus.osc_sel      = w_busy && r_osc;
  assign bus.cnt_en       = (r_state == StGate);
  assign bus.cnt_clr      = (r_state == StClear) || ((r_state == StSettle) && w_tmr_done);
  assign bus.result_valid = w_report;
  assign bus.result_data  = w_report ? r_acc : '0;
  assign bus.result_osc   = w_report && r_osc;
  assign bus.result_sat   = w_report && r_sat;

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Randomized bench: a timeline model places each window's count on cnt_in only in its
// capture cycle and predicts every control output and result from plain arithmetic.
module tb_ro_measure_sequencer;
  import ro_sense_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned S     = 4;
  localparam int unsigned G     = 10;
  localparam int unsigned Y     = 2;
  localparam int unsigned AVG   = 1;
  localparam int unsigned N     = 1 << AVG;
  localparam int          P     = G + Y + 2;
  localparam int          LREP  = S + N * (G + Y + 1) + N - 1;
  localparam int unsigned AVG_S = 8;
  localparam int          LAT_S = S + (1 << AVG_S) * (G + Y + 1) + (1 << AVG_S) - 1 + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ro_measure_sequencer_if #(.CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();
  ro_measure_sequencer_if #(.CNT_W(CNT_W), .ACC_W(ACC_W)) bus_s ();

  ro_measure_sequencer #(
    .CNT_W(CNT_W), .ACC_W(ACC_W), .GATE_CYCLES(G), .SETTLE_CYCLES(S),
    .SYNC_CYCLES(Y), .AVG_LOG2(AVG)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ro_measure_sequencer #(
    .CNT_W(CNT_W), .ACC_W(ACC_W), .GATE_CYCLES(G), .SETTLE_CYCLES(S),
    .SYNC_CYCLES(Y), .AVG_LOG2(AVG_S)
  ) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [CNT_W-1:0] win_val [N];
  logic [CNT_W-1:0] dir_val [2][N];
  bit               use_dir;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] exp_ctl(bit busy, bit osc, bit cen, bit cclr, bit vld);
    return {busy, busy & ~osc, busy & osc, busy & osc, cen, cclr, vld};
  endfunction

  function automatic logic [6:0] obs_ctl();
    return {bus.busy, bus.en_inv_osc, bus.en_nand_osc, bus.osc_sel, bus.cnt_en, bus.cnt_clr,
            bus.result_valid};
  endfunction

  task automatic fill_vals(input int osc);
    for (int w = 0; w < N; w++) begin
      if (use_dir) win_val[w] = dir_val[osc][w];
      else win_val[w] = ($urandom_range(0, 7) == 0) ? '1 : CNT_W'($urandom);
    end
  endtask

  // Called on the first SETTLE cycle; returns after the handshake edge.
  task automatic do_osc(input logic osc, input int hold, input bit noise, input bit abort_ack);
    logic [ACC_W-1:0] exp_sum;
    logic             exp_sat;
    int               rel;
    bit               gate;
    bit               clr;
    exp_sum = '0;
    exp_sat = 1'b0;
    for (int w = 0; w < N; w++) begin
      exp_sum = exp_sum + ACC_W'(win_val[w]);
      exp_sat = exp_sat | (win_val[w] == '1);
    end
    for (int off = 0; off < LREP; off++) begin
      rel  = off - int'(S);
      gate = (off >= int'(S)) && ((rel % P) < int'(G));
      clr  = (off == int'(S) - 1) || ((off >= int'(S)) && ((rel % P) == int'(G + Y + 1)));
      bus.cnt_in = CNT_W'($urandom);
      if ((off >= int'(S)) && ((rel % P) == int'(G + Y))) bus.cnt_in = win_val[rel / P];
      if (noise) begin
        bus.start    = ($urandom_range(0, 7) == 0);
        bus.osc_mask = 2'($urandom);
      end
      check_eq("ctl_run", 32'(obs_ctl()), 32'(exp_ctl(1, osc, gate, clr, 0)));
      tick();
    end
    bus.start = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      bus.cnt_in       = CNT_W'($urandom);
      bus.result_ready = (h == hold);
      bus.abort        = (h == hold) && abort_ack;
      check_eq("ctl_report", 32'(obs_ctl()), 32'(exp_ctl(1, osc, 0, 0, 1)));
      check_eq("res_data", 32'(bus.result_data), 32'(exp_sum));
      check_eq("res_osc", 32'(bus.result_osc), 32'(osc));
      check_eq("res_sat", 32'(bus.result_sat), 32'(exp_sat));
      tick();
    end
    bus.result_ready = 1'b0;
    bus.abort        = 1'b0;
  endtask

  task automatic run_round(input logic [1:0] mask, input int hold, input bit noise);
    bus.osc_mask = mask;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int o = 0; o < 2; o++) begin
      if (mask[o]) begin
        fill_vals(o);
        do_osc(o[0], hold, noise, 1'b0);
      end
    end
    check_eq("idle_ctl", 32'(obs_ctl()), 32'h0);
    check_eq("idle_data", 32'(bus.result_data), 32'h0);
  endtask

  initial begin
    int vcnt;
    int cyc;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.continuous   = 1'b0;
    bus.abort        = 1'b0;
    bus.osc_mask     = 2'b00;
    bus.cnt_in       = '0;
    bus.result_ready = 1'b0;
    bus_s.start        = 1'b0;
    bus_s.continuous   = 1'b0;
    bus_s.abort        = 1'b0;
    bus_s.osc_mask     = 2'b00;
    bus_s.cnt_in       = '1;
    bus_s.result_ready = 1'b0;
    use_dir          = 1'b0;
    repeat (3) tick();
    check_eq("rst_ctl", 32'(obs_ctl()), 32'h0);
    check_eq("rst_data", 32'(bus.result_data), 32'h0);
    rst_n = 1'b1;
    tick();

    // Directed single and dual rounds.
    use_dir = 1'b1;
    dir_val[0][0] = 16'd100; dir_val[0][1] = 16'd100;
    run_round(2'b01, 0, 0);
    dir_val[0][0] = 16'd50;  dir_val[0][1] = 16'd60;
    dir_val[1][0] = 16'd70;  dir_val[1][1] = 16'd80;
    run_round(2'b11, 0, 0);
    dir_val[1][0] = 16'hFFFF; dir_val[1][1] = 16'd5;
    run_round(2'b10, 0, 0);
    use_dir = 1'b0;

    // Backpressure.
    run_round(2'b01, 20, 0);

    // Start with an empty mask is ignored.
    bus.osc_mask = 2'b00;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("mask0_ignored", 32'(obs_ctl()), 32'h0);

    // Abort in gate cycle 5.
    bus.osc_mask = 2'b01;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int off = 0; off <= int'(S) + 4; off++) begin
      bus.cnt_in = CNT_W'($urandom);
      bus.abort  = (off == int'(S) + 4);
      tick();
    end
    bus.abort = 1'b0;
    check_eq("abort_ctl", 32'(obs_ctl()), 32'h0);
    check_eq("abort_data", 32'(bus.result_data), 32'h0);
    run_round(2'b01, 1, 0);

    // Reset asserted mid-window.
    bus.osc_mask = 2'b11;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (S + 3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ctl", 32'(obs_ctl()), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_round(2'b11, 0, 0);

    // Continuous mode on the NAND ring, then abort together with ready.
    bus.continuous = 1'b1;
    bus.osc_mask   = 2'b10;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      fill_vals(1);
      do_osc(OSC_NAND, r, 0, r == 2);
    end
    bus.continuous = 1'b0;
    check_eq("cont_abort_ctl", 32'(obs_ctl()), 32'h0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.result_valid) vcnt++;
      tick();
    end
    check_eq("no_valid_after_abort", 32'(vcnt), 32'h0);

    // Random rounds with start/mask noise while busy.
    for (int r = 0; r < 6; r++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      run_round(m, $urandom_range(0, 5), 1);
    end

    // Saturating counter with 256 windows.
    bus_s.osc_mask = 2'b01;
    bus_s.start    = 1'b1;
    tick();
    bus_s.start = 1'b0;
    cyc = 1;
    while (!bus_s.result_valid && cyc < 6000) begin
      tick();
      cyc++;
    end
    check_eq("sat_latency", 32'(cyc), 32'(LAT_S));
    check_eq("sat_data", 32'(bus_s.result_data), 32'hFFFF00);
    check_eq("sat_flag", 32'(bus_s.result_sat), 32'h1);
    bus_s.result_ready = 1'b1;
    tick();
    bus_s.result_ready = 1'b0;
    check_eq("sat_idle", 32'(bus_s.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
